fv_issue_sched: RTL and testbench
=================================

Name: fv_issue_sched

Overview:
- Schedules generated FV instructions onto the per-cycle instruction-fetch slot bus driven to the DUT; feeds the same slot bus that FV_cov monitors.
- Buffers single-instruction pushes from the FV generator in a FIFO.
- Packs up to SLOTS instructions per cycle into contiguous slots, honouring DUT stall and a per-run instruction budget.
- After the budget is spent, sequences a quiesce window before reporting done.

Parameters:
- SLOTS, 2: maximum instructions issued per cycle; equals `FV_IF_MAX_INSTR_PER_CYCLE at instantiation.
- INSTR_W, 32: instruction width; equals `FV_INSTR_WIDTH at instantiation.
- DEPTH, 8: FIFO entries; power of 2, and DEPTH >= SLOTS.
- QUIESCE, 4: idle cycles in DRAIN before DONE; must be >= 1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_  in  1  synchronous, active-high reset.
- gen_valid  in  1  generator offers gen_instr.
- gen_instr  in  INSTR_W  instruction offered.
- gen_ready  out  1  FIFO can accept; a push occurs when gen_valid & gen_ready.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- num_instr  in  8  run budget, sampled with start.
- dut_stall  in  1  DUT cannot take instructions next cycle.
- IF_instruction_out_valid  out  SLOTS  per-slot valid, bit 0 = slot 1.
- IF_instruction_out  out  SLOTS*INSTR_W  slot k occupies bits [k*INSTR_W-1:(k-1)*INSTR_W].
- busy  out  1  state is ISSUE or DRAIN.
- done  out  1  state is DONE.
- issued_cnt  out  8  instructions issued in the current run.

Behaviour:
- Reset: FIFO emptied; state IDLE; all of the following are 0: IF_instruction_out_valid, IF_instruction_out, busy, done, issued_cnt. gen_ready is 1 in the first cycle after reset.
- FIFO
  - Pushes are accepted in every state.
  - gen_ready = (count < DEPTH), using the registered count; a same-cycle pop does not raise gen_ready.
  - count_next = count + push - n_issue.
  - Pointers wrap modulo DEPTH.
- Issue count
  - n_issue = min(SLOTS, count, remaining) when state == ISSUE and !dut_stall; otherwise 0.
  - The push of the current cycle is not counted in count.
- Outputs are registered, with 1-cycle latency from the pop decision.
  - Slots 1..n_issue carry FIFO entries oldest-first.
  - Valid bits form a thermometer starting at bit 0.
  - Unused slot data is driven to 0.
  - Valid is a single-cycle pulse; the DUT must accept every asserted slot.
- State machine
  - IDLE: on start, load remaining = num_instr and clear issued_cnt. Go to DRAIN if num_instr == 0, else go to ISSUE.
  - ISSUE: remaining -= n_issue; issued_cnt += n_issue. When remaining - n_issue == 0, go to DRAIN.
  - DRAIN: counter counts QUIESCE cycles with no issue, then go to DONE.
  - DONE: done held at 1. On start, reload as in IDLE and go to ISSUE or DRAIN.
- Boundaries
  - start is ignored while busy.
  - A FIFO-empty cycle in ISSUE issues nothing and stays in ISSUE.
  - A push into a full FIFO is impossible because gen_ready is 0.
  - Leftover FIFO entries after a run are kept for the next run.
  - reset_ mid-run aborts immediately and discards FIFO contents.
  - dut_stall and start in the same cycle: the load happens; the first issue waits for !dut_stall.

Optional Feature:
- Macro: FV_ISSUE_SCHED_COV_EN.
- When defined:
  - Compiles in cover properties: all SLOTS valid in one cycle; FIFO full; dut_stall during ISSUE with count > 0; ISSUE->DRAIN transition with a partial final issue (n_issue < SLOTS).
  - Compiles in assertions: valid bits form a thermometer; issued_cnt never exceeds the loaded num_instr.
- When undefined: none of these are present.
- Sequential behaviour and ports are identical either way.

Test Plan:
- Reset, push 6 instrs 0x11..0x16, start with num_instr=5, no stall -> issued pairs (0x11,0x12), (0x13,0x14), then (0x15) with valid=01. issued_cnt=5. DRAIN 4 cycles, then done=1. 0x16 remains in the FIFO.
- Push 8 instrs with no run active -> gen_ready=0 after the 8th push; a 9th offer is not accepted. start num_instr=8 -> 4 two-slot issues; gen_ready returns to 1 one cycle after the first pop.
- ISSUE with a 4-entry FIFO, dut_stall high for 3 cycles -> no valid during the stall plus 1 cycle; order is preserved afterwards; remaining unchanged during the stall.
- start with num_instr=0 -> no valid ever; busy for QUIESCE=4 cycles; then done=1.
- reset_ asserted mid-ISSUE with 3 entries queued -> next cycle: state IDLE, valid=0, count=0, issued_cnt=0, done=0.
- Generator pushes 1/cycle into an empty FIFO during ISSUE, budget 10 -> every issue cycle shows valid=01 (single slot), 10 instrs issued in order, then DRAIN.

Source files
------------

// File: rtl/fv_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : fv_issue_sched
// Purpose  : Packs buffered FV generator instructions onto the per-cycle
//            instruction-fetch slot bus (the same bus FV_cov observes).
//            Single-instruction pushes land in a DEPTH-entry FIFO. While a
//            run is active, up to SLOTS entries per cycle are issued into
//            contiguous slots, oldest first. Issue honours dut_stall and a
//            per-run budget. Once the budget is spent, a QUIESCE-cycle
//            drain window runs before done is raised.
// Ports    : clk, reset_ (sync, active-high)
//            gen_valid/gen_instr/gen_ready   - generator push handshake
//            start/num_instr                 - run launch and budget
//            dut_stall                       - DUT back-pressure
//            IF_instruction_out_valid/_out   - registered slot bus
//            busy/done/issued_cnt            - run status
// Options  : define FV_ISSUE_SCHED_COV_EN to compile in cover properties
//            and assertions. Behaviour is identical either way.
// Revision : 1.0 - initial release
// ============================================================================
module fv_issue_sched #(
  parameter int SLOTS   = 2,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 8,
  parameter int QUIESCE = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     gen_valid,
  input  logic [INSTR_W-1:0]       gen_instr,
  output logic                     gen_ready,
  input  logic                     start,
  input  logic [7:0]               num_instr,
  input  logic                     dut_stall,
  output logic [SLOTS-1:0]         IF_instruction_out_valid,
  output logic [SLOTS*INSTR_W-1:0] IF_instruction_out,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               issued_cnt
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_CMP_W = (c_CNT_W > 8) ? c_CNT_W : 8;
  localparam int c_Q_W   = (QUIESCE > 1) ? $clog2(QUIESCE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [INSTR_W-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;
  logic [7:0]               r_remaining;
  logic [7:0]               r_issued;
  logic [c_Q_W-1:0]         r_qcnt;
  logic [SLOTS-1:0]         r_valid;
  logic [SLOTS*INSTR_W-1:0] r_data;

  logic                     w_push;
  logic                     w_load;
  logic [c_CNT_W-1:0]       w_n_issue;
  logic [7:0]               w_rem_after;
  logic [SLOTS-1:0]         w_valid;
  logic [SLOTS*INSTR_W-1:0] w_data;

  // Registered count only: a pop in this cycle frees space next cycle.
  assign gen_ready   = (r_count < c_CNT_W'(DEPTH));
  assign w_push      = gen_valid & gen_ready;
  assign w_load      = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_rem_after = r_remaining - 8'(w_n_issue);

  // n_issue = min(SLOTS, count, remaining), gated by ISSUE and !dut_stall.
  // This cycle's push is excluded because count is the registered value.
  always_comb begin
    w_n_issue = c_CNT_W'(SLOTS);
    if (r_count < w_n_issue) w_n_issue = r_count;
    if (c_CMP_W'(r_remaining) < c_CMP_W'(w_n_issue)) w_n_issue = c_CNT_W'(r_remaining);
    if ((r_state != S_ISSUE) || dut_stall) w_n_issue = '0;
  end

  // Slot k takes the k-th oldest entry. Unused slots stay at zero.
  always_comb begin
    w_valid = '0;
    w_data  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (c_CNT_W'(k) < w_n_issue) begin
        w_valid[k]                   = 1'b1;
        w_data[k*INSTR_W +: INSTR_W] = r_mem[r_rd_ptr + c_PTR_W'(k)];
      end
    end
  end

  // Storage holds no reset. Emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= gen_instr;
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_issued    <= '0;
      r_qcnt      <= '0;
      r_valid     <= '0;
      r_data      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_n_issue);
      r_count  <= r_count + c_CNT_W'(w_push) - w_n_issue;
      r_valid  <= w_valid;
      r_data   <= w_data;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_remaining <= num_instr;
            r_issued    <= '0;
            r_qcnt      <= '0;
            r_state     <= (num_instr == 8'd0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_remaining <= w_rem_after;
          r_issued    <= r_issued + 8'(w_n_issue);
          if (w_rem_after == 8'd0) begin
            r_qcnt  <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_qcnt == c_Q_W'(QUIESCE - 1)) r_state <= S_DONE;
          else                               r_qcnt  <= r_qcnt + c_Q_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IF_instruction_out_valid = r_valid;
  assign IF_instruction_out       = r_data;
  assign busy                     = (r_state == S_ISSUE) | (r_state == S_DRAIN);
  assign done                     = (r_state == S_DONE);
  assign issued_cnt               = r_issued;

`ifdef FV_ISSUE_SCHED_COV_EN
  // Budget captured at launch, kept only to bound issued_cnt.
  logic [7:0] r_loaded;
  always_ff @(posedge clk) begin
    if (reset_)      r_loaded <= '0;
    else if (w_load) r_loaded <= num_instr;
  end

  ast_valid_thermo: assert property (@(posedge clk) disable iff (reset_)
    ((r_valid & (r_valid + SLOTS'(1))) == '0));
  ast_issued_le_budget: assert property (@(posedge clk) disable iff (reset_)
    (r_issued <= r_loaded));

  cov_all_slots: cover property (@(posedge clk) disable iff (reset_) (&r_valid));
  cov_fifo_full: cover property (@(posedge clk) disable iff (reset_)
    (r_count == c_CNT_W'(DEPTH)));
  cov_stall_in_issue: cover property (@(posedge clk) disable iff (reset_)
    ((r_state == S_ISSUE) && dut_stall && (r_count != '0)));
  cov_partial_final: cover property (@(posedge clk) disable iff (reset_)
    ((r_state == S_ISSUE) && (w_n_issue != '0) && (w_rem_after == 8'd0) &&
     (w_n_issue < c_CNT_W'(SLOTS))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fv_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fv_issue_sched
// Purpose  : Self-checking bench for fv_issue_sched. A queue-based reference
//            model predicts every registered output each cycle. Directed
//            scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fv_issue_sched;

  localparam int SLOTS   = 2;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 8;
  localparam int QUIESCE = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic                     clk = 1'b0;
  logic                     reset_;
  logic                     gen_valid;
  logic [INSTR_W-1:0]       gen_instr;
  logic                     gen_ready;
  logic                     start;
  logic [7:0]               num_instr;
  logic                     dut_stall;
  logic [SLOTS-1:0]         IF_instruction_out_valid;
  logic [SLOTS*INSTR_W-1:0] IF_instruction_out;
  logic                     busy;
  logic                     done;
  logic [7:0]               issued_cnt;

  always #5 clk = ~clk;

  fv_issue_sched #(
    .SLOTS   (SLOTS),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .QUIESCE (QUIESCE)
  ) u_dut (
    .clk                      (clk),
    .reset_                   (reset_),
    .gen_valid                (gen_valid),
    .gen_instr                (gen_instr),
    .gen_ready                (gen_ready),
    .start                    (start),
    .num_instr                (num_instr),
    .dut_stall                (dut_stall),
    .IF_instruction_out_valid (IF_instruction_out_valid),
    .IF_instruction_out       (IF_instruction_out),
    .busy                     (busy),
    .done                     (done),
    .issued_cnt               (issued_cnt)
  );

  // Reference model state
  logic [INSTR_W-1:0]       m_q [$];
  int                       m_phase;
  int                       m_rem;
  int                       m_issued;
  int                       m_qleft;
  logic [SLOTS-1:0]         m_valid;
  logic [SLOTS*INSTR_W-1:0] m_data;

  int n_checks;
  int n_errors;

  task automatic t_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase  = P_IDLE;
    m_rem    = 0;
    m_issued = 0;
    m_qleft  = 0;
    m_valid  = '0;
    m_data   = '0;
  endtask

  // Check the outputs registered at the last edge, apply new inputs,
  // advance the model, then move to just after the next rising edge.
  task automatic step(input logic gv, input logic [INSTR_W-1:0] gi, input logic st,
                      input logic [7:0] num, input logic stall, input logic rst);
    int n;
    bit push;
    t_check("valid",      64'(IF_instruction_out_valid), 64'(m_valid));
    t_check("data",       64'(IF_instruction_out),       64'(m_data));
    t_check("busy",       64'(busy),       64'((m_phase == P_ISSUE) || (m_phase == P_DRAIN)));
    t_check("done",       64'(done),       64'(m_phase == P_DONE));
    t_check("issued_cnt", 64'(issued_cnt), 64'(m_issued & 255));
    t_check("gen_ready",  64'(gen_ready),  64'(m_q.size() < DEPTH));

    gen_valid = gv;
    gen_instr = gi;
    start     = st;
    num_instr = num;
    dut_stall = stall;
    reset_    = rst;

    if (rst) begin
      model_reset();
    end else begin
      push = gv && (m_q.size() < DEPTH);
      n = 0;
      if ((m_phase == P_ISSUE) && !stall) begin
        n = SLOTS;
        if (m_q.size() < n) n = m_q.size();
        if (m_rem < n)      n = m_rem;
      end
      m_valid = '0;
      m_data  = '0;
      for (int k = 0; k < n; k++) begin
        m_valid[k]                   = 1'b1;
        m_data[k*INSTR_W +: INSTR_W] = m_q.pop_front();
      end
      if (push) m_q.push_back(gi);

      case (m_phase)
        P_IDLE, P_DONE: begin
          if (st) begin
            m_rem    = int'(num);
            m_issued = 0;
            m_qleft  = QUIESCE;
            m_phase  = (num == 8'd0) ? P_DRAIN : P_ISSUE;
          end
        end
        P_ISSUE: begin
          m_rem    -= n;
          m_issued += n;
          if (m_rem == 0) begin
            m_qleft = QUIESCE;
            m_phase = P_DRAIN;
          end
        end
        default: begin
          m_qleft--;
          if (m_qleft == 0) m_phase = P_DONE;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    gen_valid = 1'b0;
    gen_instr = '0;
    start     = 1'b0;
    num_instr = 8'd0;
    dut_stall = 1'b0;
    reset_    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Push 0x11..0x16, run a budget of 5; 0x16 stays behind for the next run.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h11 + 32'(i), 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'd5, 1'b0, 1'b0);
    idle(12);
    step(1'b0, '0, 1'b1, 8'd1, 1'b0, 1'b0);
    idle(8);

    // Fill to full, offer a 9th, then drain 8 in two-slot issues.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h20 + 32'(i), 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'd8, 1'b0, 1'b0);
    idle(12);

    // Four queued, start while stalled, stall three cycles into ISSUE.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(10);

    // Zero budget goes straight to the drain window.
    do_reset();
    step(1'b0, '0, 1'b1, 8'd0, 1'b0, 1'b0);
    idle(8);

    // Reset mid-ISSUE with three entries still queued.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'd8, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
    do_reset();
    idle(4);

    // Trickle feed at one per cycle during a budget-10 run.
    do_reset();
    step(1'b0, '0, 1'b1, 8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 8'd0, 1'b0, 1'b0);
    idle(8);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0),
           $urandom,
           ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 12)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 299) == 0));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
